// File: rtl/dmd_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmd_frame_ctrl
// Brief    : Double-buffered DMD frame-buffer controller sharing one dot RAM
//            between the scan path and a host write port. The optional macro
//            DMD_CLEAR_ON_FLIP_EN zero-fills the new back page after each flip.
// Revision : 1.0
// ============================================================================
module dmd_frame_ctrl #(
   parameter int DOTS_X = 128,
   parameter int DOTS_Y = 39,
   parameter int DATA_W = 8,
   parameter int ADDR_W = 14
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        scan_req,
   input  logic [$clog2(DOTS_X)-1:0]   scan_x,
   input  logic [$clog2(DOTS_Y)-1:0]   scan_y,
   output logic                        scan_valid,
   output logic [DATA_W-1:0]           scan_data,
   input  logic                        frame_start,
   input  logic                        host_valid,
   output logic                        host_ready,
   input  logic [$clog2(DOTS_X)-1:0]   host_x,
   input  logic [$clog2(DOTS_Y)-1:0]   host_y,
   input  logic [DATA_W-1:0]           host_data,
   input  logic                        host_flip,
   output logic                        flip_pending,
   output logic                        front_page,
   output logic [ADDR_W-1:0]           ram_addr,
   output logic                        ram_we,
   output logic [DATA_W-1:0]           ram_wdata,
   input  logic [DATA_W-1:0]           ram_rdata
);

   localparam int c_x_w = $clog2(DOTS_X);
   localparam int c_y_w = $clog2(DOTS_Y);
   localparam logic [c_y_w-1:0] c_last_y = c_y_w'(DOTS_Y - 1);

   logic              r_front_page;
   logic              r_flip_pending;
   logic              r_rd_p1, r_rd_p2;
   logic              r_oor_p1, r_oor_p2;
   logic              r_scan_valid;
   logic [DATA_W-1:0] r_scan_data;
   logic [ADDR_W-1:0] r_ram_addr;
   logic              r_ram_we;
   logic [DATA_W-1:0] r_ram_wdata;

   logic              w_idle;
   logic              w_flip;
   logic              w_host_acc;
   logic              w_clr_wr;
   logic [ADDR_W-1:0] w_clr_addr;

   assign w_flip     = frame_start && w_idle && (r_flip_pending || host_flip);
   assign host_ready = !scan_req && w_idle && !r_flip_pending;
   assign w_host_acc = host_valid && host_ready;

`ifdef DMD_CLEAR_ON_FLIP_EN
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;
   localparam logic [c_x_w-1:0] c_last_x = c_x_w'(DOTS_X - 1);

   state_t           r_state, w_state_nxt;
   logic [c_x_w-1:0] r_clr_x, w_clr_x_nxt;
   logic [c_y_w-1:0] r_clr_y, w_clr_y_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_clr_x <= '0;
         r_clr_y <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_clr_x <= w_clr_x_nxt;
         r_clr_y <= w_clr_y_nxt;
      end
   end

   // Scan reads steal the slot; the clear counter simply holds on those cycles.
   always_comb begin
      w_state_nxt = r_state;
      w_clr_x_nxt = r_clr_x;
      w_clr_y_nxt = r_clr_y;
      w_clr_wr    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_flip) begin
               w_state_nxt = S_CLEAR;
               w_clr_x_nxt = '0;
               w_clr_y_nxt = '0;
            end
         end
         S_CLEAR: begin
            if (!scan_req) begin
               w_clr_wr = 1'b1;
               if (r_clr_x == c_last_x) begin
                  w_clr_x_nxt = '0;
                  if (r_clr_y == c_last_y) begin
                     w_clr_y_nxt = '0;
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_clr_y_nxt = r_clr_y + 1'b1;
                  end
               end else begin
                  w_clr_x_nxt = r_clr_x + 1'b1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_idle     = (r_state == S_IDLE);
   assign w_clr_addr = {~r_front_page, r_clr_y, r_clr_x};
`else
   assign w_idle     = 1'b1;
   assign w_clr_wr   = 1'b0;
   assign w_clr_addr = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_front_page   <= 1'b0;
         r_flip_pending <= 1'b0;
      end else if (w_flip) begin
         r_front_page   <= ~r_front_page;
         r_flip_pending <= 1'b0;
      end else if (host_flip) begin
         r_flip_pending <= 1'b1;
      end
   end

   // Single RAM slot per cycle: scan read, then clear write, then host write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ram_addr  <= '0;
         r_ram_we    <= 1'b0;
         r_ram_wdata <= '0;
      end else begin
         r_ram_we <= 1'b0;
         if (scan_req) begin
            r_ram_addr <= {r_front_page, scan_y, scan_x};
         end else if (w_clr_wr) begin
            r_ram_addr  <= w_clr_addr;
            r_ram_we    <= 1'b1;
            r_ram_wdata <= '0;
         end else if (w_host_acc) begin
            r_ram_addr  <= {~r_front_page, host_y, host_x};
            r_ram_we    <= (host_y <= c_last_y);
            r_ram_wdata <= host_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_p1      <= 1'b0;
         r_rd_p2      <= 1'b0;
         r_oor_p1     <= 1'b0;
         r_oor_p2     <= 1'b0;
         r_scan_valid <= 1'b0;
         r_scan_data  <= '0;
      end else begin
         r_rd_p1      <= scan_req;
         r_oor_p1     <= (scan_y > c_last_y);
         r_rd_p2      <= r_rd_p1;
         r_oor_p2     <= r_oor_p1;
         r_scan_valid <= r_rd_p2;
         if (r_rd_p2) begin
            r_scan_data <= r_oor_p2 ? '0 : ram_rdata;
         end
      end
   end

   assign front_page   = r_front_page;
   assign flip_pending = r_flip_pending;
   assign scan_valid   = r_scan_valid;
   assign scan_data    = r_scan_data;
   assign ram_addr     = r_ram_addr;
   assign ram_we       = r_ram_we;
   assign ram_wdata    = r_ram_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dmd_frame_ctrl.sv
`default_nettype none
// tb_dmd_frame_ctrl : directed checks of dmd_frame_ctrl against a behavioural
// single-port synchronous RAM; the clear sequence runs when DMD_CLEAR_ON_FLIP_EN is set.
module tb_dmd_frame_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        scan_req = 1'b0;
   logic [6:0]  scan_x = '0;
   logic [5:0]  scan_y = '0;
   logic        scan_valid;
   logic [7:0]  scan_data;
   logic        frame_start = 1'b0;
   logic        host_valid = 1'b0;
   logic        host_ready;
   logic [6:0]  host_x = '0;
   logic [5:0]  host_y = '0;
   logic [7:0]  host_data = '0;
   logic        host_flip = 1'b0;
   logic        flip_pending;
   logic        front_page;
   logic [13:0] ram_addr;
   logic        ram_we;
   logic [7:0]  ram_wdata;
   logic [7:0]  ram_rdata = '0;

   logic [7:0]  mem [0:16383] = '{default: 8'hEE};

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
   end

   dmd_frame_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .scan_req(scan_req), .scan_x(scan_x), .scan_y(scan_y),
      .scan_valid(scan_valid), .scan_data(scan_data),
      .frame_start(frame_start),
      .host_valid(host_valid), .host_ready(host_ready),
      .host_x(host_x), .host_y(host_y), .host_data(host_data),
      .host_flip(host_flip), .flip_pending(flip_pending), .front_page(front_page),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

`ifdef DMD_CLEAR_ON_FLIP_EN
   int cyc, nwr, nscan, bad;
   logic [6:0] ex;
   logic [5:0] ey;
`endif

   initial begin
      #12;
      chk("rst_front", front_page, 0);
      chk("rst_pend", flip_pending, 0);
      chk("rst_valid", scan_valid, 0);
      chk("rst_data", scan_data, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_ready", host_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;

`ifndef DMD_CLEAR_ON_FLIP_EN
      // read latency
      host_valid = 1; host_x = 5; host_y = 3; host_data = 8'hA5;
      #1 chk("wr_ready", host_ready, 1);
      tick();
      chk("wr_we", ram_we, 1);
      chk("wr_addr", ram_addr, 14'h2185);
      chk("wr_data", ram_wdata, 8'hA5);
      host_valid = 0; host_flip = 1;
      tick();
      host_flip = 0;
      chk("arm_pend", flip_pending, 1);
      chk("arm_we_off", ram_we, 0);
      chk("arm_ready", host_ready, 0);
      frame_start = 1;
      tick();
      frame_start = 0;
      chk("flip_front", front_page, 1);
      chk("flip_pend", flip_pending, 0);
      chk("flip_ready", host_ready, 1);
      scan_req = 1; scan_x = 5; scan_y = 3;
      tick();
      scan_req = 0;
      chk("rd_addr", ram_addr, 14'h2185);
      chk("rd_we", ram_we, 0);
      chk("rd_v0", scan_valid, 0);
      tick();
      chk("rd_v1", scan_valid, 0);
      tick();
      chk("rd_v2", scan_valid, 1);
      chk("rd_data", scan_data, 8'hA5);
      tick();
      chk("rd_v3", scan_valid, 0);

      // collision: scan wins, host write issued the following cycle
      host_valid = 1; host_x = 2; host_y = 2; host_data = 8'h11;
      scan_req = 1; scan_x = 5; scan_y = 3;
      #1 chk("col_ready", host_ready, 0);
      tick();
      scan_req = 0;
      chk("col_rd_addr", ram_addr, 14'h2185);
      chk("col_rd_we", ram_we, 0);
      #1 chk("col_ready2", host_ready, 1);
      tick();
      host_valid = 0;
      chk("col_wr_we", ram_we, 1);
      chk("col_wr_addr", ram_addr, 14'h0102);
      chk("col_wr_data", ram_wdata, 8'h11);
      tick();
      chk("col_rd_valid", scan_valid, 1);
      chk("col_rd_data", scan_data, 8'hA5);

      // flip stall: pending flip blocks host writes until frame_start
      host_flip = 1;
      tick();
      host_flip = 0;
      host_valid = 1; host_x = 1; host_y = 1; host_data = 8'h22;
      #1 chk("stall_ready", host_ready, 0);
      chk("stall_pend", flip_pending, 1);
      tick();
      chk("stall_we", ram_we, 0);
      chk("stall_ready2", host_ready, 0);
      frame_start = 1;
      tick();
      frame_start = 0;
      chk("stall_front", front_page, 0);
      chk("stall_pend2", flip_pending, 0);
      chk("stall_ready3", host_ready, 1);
      tick();
      host_valid = 0;
      chk("stall_wr_we", ram_we, 1);
      chk("stall_wr_addr", ram_addr, 14'h2081);
      chk("stall_wr_data", ram_wdata, 8'h22);

      // immediate flip, then a repeated host_flip arming only one flip
      host_flip = 1; frame_start = 1;
      tick();
      frame_start = 0;
      chk("imm_front", front_page, 1);
      chk("imm_pend", flip_pending, 0);
      tick();
      tick();
      host_flip = 0;
      chk("dbl_pend", flip_pending, 1);
      chk("dbl_front", front_page, 1);
      frame_start = 1;
      tick();
      frame_start = 0;
      chk("dbl_front2", front_page, 0);
      chk("dbl_pend2", flip_pending, 0);
      tick();
      chk("dbl_pend3", flip_pending, 0);

      // out-of-range write and back-to-back reads
      host_valid = 1; host_x = 0; host_y = 39; host_data = 8'h33;
      #1 chk("oor_ready", host_ready, 1);
      tick();
      host_valid = 0;
      chk("oor_we", ram_we, 0);
      scan_req = 1; scan_x = 2; scan_y = 2;
      tick();
      scan_x = 5; scan_y = 3;
      tick();
      scan_x = 3; scan_y = 45;
      tick();
      scan_req = 0;
      chk("b2b_addr", ram_addr, 14'h1683);
      chk("b2b_v0", scan_valid, 1);
      chk("b2b_d0", scan_data, 8'h11);
      tick();
      chk("b2b_v1", scan_valid, 1);
      chk("b2b_d1", scan_data, 8'hEE);
      tick();
      chk("b2b_v2", scan_valid, 1);
      chk("b2b_d2", scan_data, 8'h00);
      tick();
      chk("b2b_v3", scan_valid, 0);

      // async reset with a read in flight and a write on the RAM port
      host_flip = 1; frame_start = 1;
      tick();
      host_flip = 0; frame_start = 0;
      scan_req = 1; scan_x = 0; scan_y = 0;
      tick();
      scan_req = 0;
      host_valid = 1; host_x = 4; host_y = 4; host_data = 8'h44;
      tick();
      host_valid = 0;
      chk("pre_rst_we", ram_we, 1);
      chk("pre_rst_front", front_page, 1);
      #2 rst_n = 0;
      #1;
      chk("arst_front", front_page, 0);
      chk("arst_we", ram_we, 0);
      chk("arst_addr", ram_addr, 0);
      chk("arst_wdata", ram_wdata, 0);
      chk("arst_valid", scan_valid, 0);
      @(posedge clk); #1;
      rst_n = 1;
      tick();
      chk("post_rst_valid", scan_valid, 0);
      chk("post_rst_ready", host_ready, 1);
`else
      // clear after flip, with scan reads stealing every 10th cycle
      host_flip = 1; frame_start = 1;
      tick();
      host_flip = 0; frame_start = 0;
      chk("clr_front", front_page, 1);
      chk("clr_ready", host_ready, 0);
      cyc = 0; nwr = 0; nscan = 0; bad = 0; ex = '0; ey = '0;
      while (nwr < 4992 && cyc < 7000) begin
         scan_req = ((cyc % 10) == 9); scan_x = 1; scan_y = 1;
         host_flip = (cyc == 100);
         frame_start = (cyc == 200);
         #1;
         if (host_ready !== 1'b0) bad++;
         tick();
         if (scan_req) begin
            nscan++;
            if (ram_we !== 1'b0) bad++;
         end else begin
            if (ram_we !== 1'b1 || ram_wdata !== 8'h00 || ram_addr !== {1'b0, ey, ex}) bad++;
            nwr++;
            if (ex == 7'd127) begin
               ex = '0;
               ey = ey + 1'b1;
            end else begin
               ex = ex + 1'b1;
            end
         end
         cyc++;
      end
      scan_req = 0; host_flip = 0; frame_start = 0;
      chk("clr_writes", nwr, 4992);
      chk("clr_bad", bad, 0);
      chk("clr_cycles", cyc, 4992 + nscan);
      chk("clr_front_kept", front_page, 1);
      chk("clr_pend_kept", flip_pending, 1);
      tick();
      chk("clr_done_we", ram_we, 0);

      // second flip starts a clear of page 1, then reset mid-clear
      frame_start = 1;
      tick();
      frame_start = 0;
      chk("clr2_front", front_page, 0);
      chk("clr2_pend", flip_pending, 0);
      tick();
      chk("clr2_we", ram_we, 1);
      chk("clr2_addr", ram_addr, 14'h2000);
      tick();
      #2 rst_n = 0;
      #1;
      chk("arst_front", front_page, 0);
      chk("arst_we", ram_we, 0);
      chk("arst_addr", ram_addr, 0);
      chk("arst_valid", scan_valid, 0);
      @(posedge clk); #1;
      rst_n = 1;
      #1 chk("post_rst_ready", host_ready, 1);
      tick();
      chk("post_rst_we", ram_we, 0);
      tick();
      chk("post_rst_we2", ram_we, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
